rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource (e.g. a bus or memory port) among 2**N_SEL_BITS requesters.
- Tracks a rotating priority pointer and holds each grant until the owner signals completion.
- Drives a registered grant index, plus a one-hot grant vector produced from that index by the existing dec decoder.
- Sits between core-side masters and the shared resource's select/mux logic.

---
 rtl/arb_pkg.sv | 33 +++
 rtl/dec.sv | 16 +
 rtl/rr_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority pick function for the round-robin arbiter.
package arb_pkg;

  // Widest arbiter the pick function supports (32 requesters).
  localparam int unsigned ARB_MAX_SEL_BITS = 5;
  localparam int unsigned ARB_MAX_REQ      = 1 << ARB_MAX_SEL_BITS;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Returns the first set request scanning ptr, ptr+1, ... modulo n_req.
  // The result is meaningless when no request is set; callers gate on |req.
  function automatic int unsigned rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n_req);
    int unsigned pick;
    int unsigned j;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      j = (ptr + i) % n_req;
      if (i < n_req && !found && req[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec.sv
// Binary-to-one-hot decoder: sets exactly one output bit selected by i_sel.
module dec #(
  parameter int N_SEL_BITS = 2
) (
  input  logic [N_SEL_BITS-1:0]    i_sel,
  output logic [2**N_SEL_BITS-1:0] o_dec
);

  // NOTE: assigning a default before the indexed write keeps this purely
  // combinational; skipping it would infer a latch.
  always_comb begin
    o_dec        = '0;
    o_dec[i_sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold until done/request drop.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_SEL_BITS = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2**N_SEL_BITS-1:0] i_req,
  input  logic                    i_done,
  output logic                    o_gnt_valid,
  output logic [N_SEL_BITS-1:0]   o_gnt_idx,
  output logic [2**N_SEL_BITS-1:0] o_gnt,
  output logic                    o_timeout
);

  localparam int N_REQ = 2**N_SEL_BITS;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_e              state, state_n;
  logic [N_SEL_BITS-1:0]   ptr, ptr_n;
  logic [N_SEL_BITS-1:0]   idx_n;
  logic [N_SEL_BITS-1:0]   scan_ptr;
  logic [N_SEL_BITS-1:0]   pick;
  logic [N_SEL_BITS-1:0]   idx_inc;
  logic                    valid_n;
  logic                    any_req;
  logic                    release_now;
  logic                    timeout_hit;
  logic [N_REQ-1:0]        raw_gnt;

  assign any_req = |i_req;
  assign idx_inc = o_gnt_idx + N_SEL_BITS'(1);

  // While a grant is active the only pick that matters is the one on release,
  // which starts just past the current owner so it gets lowest priority.
  assign scan_ptr = (state == ARB_GRANT) ? idx_inc : ptr;
  assign pick     = N_SEL_BITS'(rr_pick(ARB_MAX_REQ'(i_req), 32'(scan_ptr), N_REQ));

  // A dropped request counts as an implicit done.
  assign release_now = (state == ARB_GRANT) &&
                       (i_done || !i_req[o_gnt_idx] || timeout_hit);

  always_comb begin
    state_n = state;
    idx_n   = o_gnt_idx;
    valid_n = o_gnt_valid;
    ptr_n   = ptr;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_n = ARB_GRANT;
          idx_n   = pick;
          valid_n = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          ptr_n = idx_inc;
          if (any_req) begin
            idx_n = pick;
          end else begin
            state_n = ARB_IDLE;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      o_gnt_idx   <= '0;
      o_gnt_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      o_gnt_idx   <= idx_n;
      o_gnt_valid <= valid_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  // A done or request drop in the final cycle wins: that is a normal release.
  assign timeout_hit = (state == ARB_GRANT) &&
                       (hold_cnt == HOLD_W'(MAX_HOLD - 1)) &&
                       !i_done && i_req[o_gnt_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state_n == ARB_GRANT && (state == ARB_IDLE || release_now)) begin
        hold_cnt <= '0;
      end else if (state == ARB_GRANT) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  dec #(
    .N_SEL_BITS(N_SEL_BITS)
  ) u_dec (
    .i_sel(o_gnt_idx),
    .o_dec(raw_gnt)
  );

  assign o_gnt = raw_gnt & {N_REQ{o_gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N_SEL_BITS=2, MAX_HOLD=4); covers both
// builds of ARB_TIMEOUT_EN.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] gnt;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter #(
    .N_SEL_BITS(2),
    .MAX_HOLD  (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_done     (done),
    .o_gnt_valid(gnt_valid),
    .o_gnt_idx  (gnt_idx),
    .o_gnt      (gnt),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       exp_valid;
    logic       chk_idx;
    logic [1:0] exp_idx;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // req, done -> valid, check idx?, idx, gnt after the next edge
    vecs[0]  = '{4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[1]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[2]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[3]  = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[4]  = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[5]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[6]  = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[7]  = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[8]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[9]  = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[10] = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[11] = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[12] = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[13] = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[14] = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[15] = '{4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[16] = '{4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[17] = '{4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[18] = '{4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[19] = '{4'b0110, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[20] = '{4'b0110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[21] = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[22] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[23] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    // Pointer held at 3 through IDLE: 1010 must go to requester 3, not 1.
    vecs[24] = '{4'b1010, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000};

    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    #12;
    check("reset valid", 32'(gnt_valid), 32'd0);
    check("reset idx", 32'(gnt_idx), 32'd0);
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check($sformatf("vec%0d valid", i), 32'(gnt_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d timeout", i), 32'(timeout), 32'd0);
      if (vecs[i].chk_idx) begin
        check($sformatf("vec%0d idx", i), 32'(gnt_idx), 32'(vecs[i].exp_idx));
      end
    end

    // Mid-grant reset: owner 2 with pointer moved to 2, then async reset.
    req  = 4'b0010;
    done = 1'b1;
    step();
    check("pre-rst owner1", 32'(gnt_idx), 32'd1);
    req = 4'b0100;
    step();
    check("pre-rst gnt", 32'(gnt), 32'b0100);
    done = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(gnt_valid), 32'd0);
    check("async rst idx", 32'(gnt_idx), 32'd0);
    check("async rst gnt", 32'(gnt), 32'd0);
    req = 4'b1111;
    #1;
    rst = 1'b0;
    step();
    check("post-rst idx", 32'(gnt_idx), 32'd0);
    check("post-rst gnt", 32'(gnt), 32'b0001);

    // Hold limit: owner 0 held without done, requester 1 waiting.
    pulse_reset();
    req  = 4'b0011;
    done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("hold cyc%0d idx", c), 32'(gnt_idx), 32'd0);
      check($sformatf("hold cyc%0d timeout", c), 32'(timeout), 32'd0);
    end
    step();
`ifdef ARB_TIMEOUT_EN
    check("forced idx", 32'(gnt_idx), 32'd1);
    check("forced timeout", 32'(timeout), 32'd1);
    step();
    check("after forced idx", 32'(gnt_idx), 32'd1);
`else
    check("no preempt idx", 32'(gnt_idx), 32'd0);
    check("no preempt timeout", 32'(timeout), 32'd0);
    step();
    check("still held idx", 32'(gnt_idx), 32'd0);
`endif
    check("timeout single pulse", 32'(timeout), 32'd0);
    check("hold valid", 32'(gnt_valid), 32'd1);

    // Done in the final hold cycle is a normal release.
    pulse_reset();
    req  = 4'b0011;
    done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
    end
    check("done-last pre idx", 32'(gnt_idx), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    check("done-last idx", 32'(gnt_idx), 32'd1);
    check("done-last timeout", 32'(timeout), 32'd0);
    step();
    check("done-last after timeout", 32'(timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
